// File: rtl/dlx_reg_monitor.sv
// dlx_reg_monitor: register-file observation unit for the DLX core.
// Shows the low OUT_W bits of one architectural register on regs_o, with
// the shown register picked by a fixed selector, a slow round-robin scan, or a
// watch target. In watch mode it also flags writeback hits on the target.
// All outputs are registered.
//
// Build option: define MON_STICKY_HIT_EN to make hit_o sticky. It then stays
// set until the unit leaves WATCH. Without the macro, hit_o is a one-cycle
// pulse per hit. hit_count_o behaves the same in both builds.
module dlx_reg_monitor #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int SEL_W    = 5,
    parameter int OUT_W    = 7,
    parameter int SCAN_DIV = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [NUM_REGS*DATA_W-1:0]   regs_flat_i,
    input  logic                         reg_write_en_i,
    input  logic [SEL_W-1:0]             reg_add_i,
    input  logic [1:0]                   mode_i,
    input  logic [SEL_W-1:0]             sel_i,
    input  logic                         freeze_i,
    output logic [OUT_W-1:0]             regs_o,
    output logic [SEL_W-1:0]             chan_o,
    output logic                         valid_o,
    output logic                         hit_o,
    output logic [15:0]                  hit_count_o
);

    // Every selector code gets a tap. Codes at or beyond NUM_REGS read as
    // zero, which keeps the mux total and avoids indexing past the bus.
    localparam int NUM_CH = 2 ** SEL_W;

    // The divider is at least one bit wide, so SCAN_DIV=1 still builds.
    // In that case the scan advances every cycle.
    localparam int               DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] LAST_CHAN  = SEL_W'(NUM_REGS - 1);
    localparam logic [SEL_W:0]   NUM_REGS_X = (SEL_W + 1)'(NUM_REGS);

    localparam logic [15:0]      COUNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_FIXED  = 2'd0,
        ST_SCAN   = 2'd1,
        ST_WATCH  = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     chan_q, chan_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [OUT_W-1:0]     regs_q, regs_d;
    logic                 valid_q, valid_d;
    logic                 hit_q, hit_d;
    logic [15:0]          hit_count_q, hit_count_d;

    logic [OUT_W-1:0]     reg_tap [NUM_CH];
    logic                 sel_in_range;
    logic [SEL_W-1:0]     sel_chan;
    logic                 watch_hit;

    // Low OUT_W bits of every visible register, padded to the full selector range
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_tap
            if (gi < NUM_REGS) begin : g_live
                assign reg_tap[gi] = regs_flat_i[gi*DATA_W +: OUT_W];
            end else begin : g_pad
                assign reg_tap[gi] = '0;
            end
        end
    endgenerate

    // Clamp an out-of-range selector to r0
    always_comb begin
        sel_in_range = ({1'b0, sel_i} < NUM_REGS_X);
        sel_chan     = sel_in_range ? sel_i : '0;
    end

    // Next state: freeze overrides everything, otherwise decode mode_i (11 acts as FIXED)
    always_comb begin
        state_d = ST_FIXED;
        if (freeze_i) begin
            state_d = ST_FROZEN;
        end else begin
            case (mode_i)
                2'b01:   state_d = ST_SCAN;
                2'b10:   state_d = ST_WATCH;
                default: state_d = ST_FIXED;
            endcase
        end
    end

    // Channel choice, scan divider and sampled register value for the coming edge
    always_comb begin
        chan_d = chan_q;
        div_d  = div_q;
        regs_d = regs_q;
        case (state_d)
            ST_FIXED, ST_WATCH: begin
                chan_d = sel_chan;
                regs_d = reg_tap[sel_chan];
            end
            ST_SCAN: begin
                // A fresh scan from FIXED/WATCH restarts the divider on the
                // current channel. Coming back from FROZEN keeps the divider
                // so the scan resumes where it was held.
                if (state_q == ST_FIXED || state_q == ST_WATCH) begin
                    div_d = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    chan_d = (chan_q == LAST_CHAN) ? '0 : chan_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
                regs_d = reg_tap[chan_d];
            end
            default: begin
                // FROZEN: display, channel and divider all hold
            end
        endcase
    end

    // Watch-hit detection, hit flag and saturating hit counter
    always_comb begin
        // Freezing in the same cycle as a write suppresses the hit, because
        // state_d is then FROZEN rather than WATCH.
        watch_hit   = (state_d == ST_WATCH) && reg_write_en_i &&
                      (reg_add_i == sel_i) && (reg_add_i != '0);
        hit_count_d = hit_count_q;
        if (watch_hit && hit_count_q != COUNT_MAX) begin
            hit_count_d = hit_count_q + 16'd1;
        end
`ifdef MON_STICKY_HIT_EN
        hit_d = (state_d == ST_WATCH) && (hit_q || watch_hit);
`else
        hit_d = watch_hit;
`endif
        valid_d = 1'b1;
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_FIXED;
            chan_q      <= '0;
            div_q       <= '0;
            regs_q      <= '0;
            valid_q     <= 1'b0;
            hit_q       <= 1'b0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            div_q       <= div_d;
            regs_q      <= regs_d;
            valid_q     <= valid_d;
            hit_q       <= hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign regs_o      = regs_q;
    assign chan_o      = chan_q;
    assign valid_o     = valid_q;
    assign hit_o       = hit_q;
    assign hit_count_o = hit_count_q;

endmodule
